parity_frame_rx: RTL and testbench



---
 rtl/parity_link_pkg.sv | 14 +
 rtl/parity_frame_rx.sv | 113 +++++++++++
 tb/tb_parity_frame_rx.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/parity_link_pkg.sv
// Shared definitions for the XOR-parity serial link (receiver and transmitter).
// Holds the frame state encoding and the parity-mode constants.
package parity_link_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } link_state_e;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: assembles DATA_W bits LSB first plus one parity bit,
// then presents the word with a parity-error flag for one data_valid pulse.
//
// state  | meaning
// IDLE   | waiting for an sof beat
// DATA   | collecting data bits 1..DATA_W-1
// PARITY | next valid beat is the parity bit
module parity_frame_rx
    import parity_link_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter bit ODD    = PAR_EVEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic              rx_bit,
    input  logic              rx_sof,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    link_state_e       r_state;
    link_state_e       w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              r_xor;
    logic              w_xor_nxt;
    logic              w_emit;
    logic              w_err;

    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;
    logic              r_parity_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_xor   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_xor   <= w_xor_nxt;
        end
    end

    // An sof beat restarts the frame from any state; an interrupted frame is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_xor_nxt   = r_xor;
        w_emit      = 1'b0;
        w_err       = r_xor ^ rx_bit ^ ODD;
        if (rx_valid) begin
            if (rx_sof) begin
                w_shift_nxt    = '0;
                w_shift_nxt[0] = rx_bit;
                w_xor_nxt      = rx_bit;
                w_cnt_nxt      = CW'(1);
                w_state_nxt    = DATA;
            end else begin
                case (r_state)
                    DATA: begin
                        for (int i = 0; i < DATA_W; i++) begin
                            if (r_cnt == CW'(i)) w_shift_nxt[i] = rx_bit;
                        end
                        w_xor_nxt = r_xor ^ rx_bit;
                        w_cnt_nxt = r_cnt + 1'b1;
                        if (r_cnt == LAST_BIT) w_state_nxt = PARITY;
                    end
                    PARITY: begin
                        w_emit      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_xor_nxt   = 1'b0;
                        w_state_nxt = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_data_valid <= w_emit;
            if (w_emit) begin
                r_data_out   <= r_shift;
                r_parity_err <= w_err;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign parity_err = r_parity_err;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: even and odd instances share one stimulus stream
// and are checked every cycle against a frame-level model, plus directed frames.
module tb_parity_frame_rx;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_valid = 1'b0;
    logic              rx_bit = 1'b0;
    logic              rx_sof = 1'b0;
    logic [DATA_W-1:0] data_out0, data_out1;
    logic              data_valid0, data_valid1;
    logic              parity_err0, parity_err1;
    logic              busy0, busy1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    parity_frame_rx #(.DATA_W(DATA_W), .ODD(1'b0)) u_even (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_bit(rx_bit), .rx_sof(rx_sof),
        .data_out(data_out0), .data_valid(data_valid0), .parity_err(parity_err0), .busy(busy0)
    );

    parity_frame_rx #(.DATA_W(DATA_W), .ODD(1'b1)) u_odd (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_bit(rx_bit), .rx_sof(rx_sof),
        .data_out(data_out1), .data_valid(data_valid1), .parity_err(parity_err1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: collect the bits seen since the last sof; a full frame
    // of DATA_W+1 bits yields a word and the XOR of all its bits decides the error.
    logic              m_bits[DATA_W+1];
    int                m_n;
    logic              m_in;
    logic [DATA_W-1:0] m_word;
    logic              m_err_even, m_err_odd, m_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0; m_in = 1'b0; m_word = '0;
            m_err_even = 1'b0; m_err_odd = 1'b0; m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (rx_valid) begin
                if (rx_sof) begin
                    m_bits[0] = rx_bit; m_n = 1; m_in = 1'b1;
                end else if (m_in) begin
                    m_bits[m_n] = rx_bit;
                    m_n++;
                    if (m_n == DATA_W + 1) begin
                        int ones;
                        ones = 0;
                        for (int i = 0; i < DATA_W; i++) m_word[i] = m_bits[i];
                        for (int i = 0; i <= DATA_W; i++) ones += int'(m_bits[i]);
                        m_err_even = (ones % 2) != 0;
                        m_err_odd  = (ones % 2) == 0;
                        m_valid = 1'b1;
                        m_in = 1'b0;
                        m_n = 0;
                    end
                end
            end
        end
    end

    int                cyc = 0;
    int                n_pulse = 0;
    int                pulse_cyc[$];
    logic [DATA_W-1:0] last_word;
    logic              last_err0, last_err1;

    always @(negedge clk) begin
        cyc++;
        chk("valid_even", 32'(data_valid0), 32'(m_valid));
        chk("valid_odd",  32'(data_valid1), 32'(m_valid));
        chk("data_even",  32'(data_out0),   32'(m_word));
        chk("data_odd",   32'(data_out1),   32'(m_word));
        chk("err_even",   32'(parity_err0), 32'(m_err_even));
        chk("err_odd",    32'(parity_err1), 32'(m_err_odd));
        chk("busy_even",  32'(busy0),       32'(m_in));
        chk("busy_odd",   32'(busy1),       32'(m_in));
        if (data_valid0) begin
            n_pulse++;
            pulse_cyc.push_back(cyc);
            last_word = data_out0;
            last_err0 = parity_err0;
            last_err1 = parity_err1;
        end
    end

    task automatic beat(input logic v, input logic b, input logic s);
        @(negedge clk);
        rx_valid = v; rx_bit = b; rx_sof = s;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bits(input logic [DATA_W-1:0] w, input int nbits, input int max_gap);
        for (int i = 0; i < nbits; i++) begin
            if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
            beat(1'b1, w[i], i == 0);
        end
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] w, input logic par, input int max_gap);
        send_bits(w, DATA_W, max_gap);
        if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
        beat(1'b1, par, 1'b0);
    endtask

    task automatic expect_frame(input string name, input int pulses, input logic [DATA_W-1:0] w,
                                input logic e0, input logic e1);
        chk({name, "_pulses"}, 32'(n_pulse), 32'(pulses));
        chk({name, "_word"},   32'(last_word), 32'(w));
        chk({name, "_err0"},   32'(last_err0), 32'(e0));
        chk({name, "_err1"},   32'(last_err1), 32'(e1));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_data",  32'(data_out0),   32'h0);
        chk("reset_valid", 32'(data_valid0), 32'h0);
        chk("reset_busy",  32'(busy0),       32'h0);
        rst_n = 1'b1;
        idle(2);

        n_pulse = 0;
        send_frame(8'hA5, 1'b0, 0);
        idle(3);
        expect_frame("a5", 1, 8'hA5, 1'b0, 1'b1);

        n_pulse = 0;
        send_frame(8'h01, 1'b0, 0);
        idle(3);
        expect_frame("err01", 1, 8'h01, 1'b1, 1'b0);

        n_pulse = 0;
        send_frame(8'h3C, 1'b0, 5);
        idle(3);
        expect_frame("stall3c", 1, 8'h3C, 1'b0, 1'b1);

        n_pulse = 0;
        send_bits(8'h0F, 5, 0);
        send_frame(8'hFF, 1'b0, 0);
        idle(3);
        expect_frame("abort", 1, 8'hFF, 1'b0, 1'b1);

        n_pulse = 0;
        pulse_cyc.delete();
        send_frame(8'h12, 1'b0, 0);
        send_frame(8'h34, 1'b1, 0);
        idle(3);
        chk("b2b_pulses", 32'(n_pulse), 32'd2);
        if (pulse_cyc.size() == 2)
            chk("b2b_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'(DATA_W + 1));
        expect_frame("b2b", 2, 8'h34, 1'b0, 1'b1);

        send_bits(8'h1F, 5, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data",  32'(data_out0),   32'h0);
        chk("rst_err",   32'(parity_err1), 32'h0);
        chk("rst_busy",  32'(busy0),       32'h0);
        chk("rst_valid", 32'(data_valid0), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        n_pulse = 0;
        idle(2);
        send_bits(8'hAA, 3, 0);
        beat(1'b0, 1'b0, 1'b0);
        chk("rst_no_partial", 32'(n_pulse), 32'd0);
        n_pulse = 0;
        send_frame(8'h5A, 1'b0, 0);
        idle(3);
        expect_frame("post_rst", 1, 8'h5A, 1'b0, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            beat($urandom_range(9, 0) < 7, 1'($urandom), $urandom_range(11, 0) == 0);
        end
        n_pulse = 0;
        for (int i = 0; i < 20; i++) send_frame(8'($urandom), 1'($urandom), 2);
        idle(3);
        chk("rand_pulses", 32'(n_pulse), 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
